// File: rtl/seg7_mux2_drv.sv
// seg7_mux2_drv: two-digit multiplexed 7-segment scanner (GAP_A/TENS/GAP_B/ONES), valid/ready value latch, polarity-selectable seg_out/com_out, com_oe
module seg7_mux2_drv #(
  parameter int PRESCALE    = 1024,
  parameter int ON_TICKS    = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] value_bcd,
  input  logic [1:0] value_dp,
  input  logic       value_valid,
  output logic       value_ready,
  input  logic       lz_blank,
  input  logic       com_pol,
  input  logic       seg_pol,
  output logic [7:0] seg_out,
  output logic [1:0] com_out,
  output logic [1:0] com_oe
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2((ON_TICKS > BLANK_TICKS ? ON_TICKS : BLANK_TICKS) + 1);
  typedef enum logic [1:0] {GAP_A, TENS, GAP_B, ONES} state_t;
  state_t        state;
  logic [PW-1:0] pre;
  logic [DW-1:0] dwell;
  logic [7:0]    bcd;
  logic [1:0]    dp;
  logic [1:0]    com_act, com_nxt;
  logic [7:0]    seg_act, seg_nxt;
  logic [6:0]    glyph;
  logic [3:0]    digit;
  logic          tick, lit, last;
  assign tick        = ena && pre == PW'(PRESCALE - 1);
  assign lit         = state == TENS || state == ONES;
  assign last        = dwell == DW'((lit ? ON_TICKS : BLANK_TICKS) - 1);
  assign value_ready = ena && state == GAP_A;
  assign digit       = state == TENS ? bcd[7:4] : bcd[3:0];
  always_comb begin
    glyph = 7'h00;
    case (digit)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end
  assign com_nxt = state == TENS ? 2'b10 : state == ONES ? 2'b01 : 2'b00;
  assign seg_nxt = state == TENS ? {dp[1], (lz_blank && bcd[7:4] == 4'h0) ? 7'h00 : glyph}
                 : state == ONES ? {dp[0], glyph} : 8'h00;
  assign com_out = com_pol ? com_act : ~com_act;
  assign seg_out = seg_pol ? seg_act : ~seg_act;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      state   <= GAP_A;
      dwell   <= '0;
      bcd     <= 8'h00;
      dp      <= 2'b00;
      com_act <= 2'b00;
      seg_act <= 8'h00;
      com_oe  <= 2'b00;
    end else begin
      com_oe  <= 2'b11;
      com_act <= ena ? com_nxt : 2'b00;
      seg_act <= ena ? seg_nxt : 8'h00;
      if (value_valid && value_ready) begin
        bcd <= value_bcd;
        dp  <= value_dp;
      end
      if (ena) pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        dwell <= last ? '0 : dwell + 1'b1;
        if (last) state <= state_t'(state + 2'd1);
      end
    end
  end
endmodule

// File: tb/tb_seg7_mux2_drv.sv
// tb_seg7_mux2_drv: directed self-checking bench for seg7_mux2_drv with PRESCALE=4, ON_TICKS=2, BLANK_TICKS=1 (24-clk frame)
module tb_seg7_mux2_drv;
  logic       clk = 1'b0;
  logic       rst_n, ena, value_valid, value_ready, lz_blank, com_pol, seg_pol;
  logic [7:0] value_bcd, seg_out;
  logic [1:0] value_dp, com_out, com_oe;
  int checks = 0;
  int failures = 0;
  seg7_mux2_drv #(.PRESCALE(4), .ON_TICKS(2), .BLANK_TICKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .value_bcd(value_bcd), .value_dp(value_dp),
    .value_valid(value_valid), .value_ready(value_ready), .lz_blank(lz_blank),
    .com_pol(com_pol), .seg_pol(seg_pol), .seg_out(seg_out), .com_out(com_out), .com_oe(com_oe)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    assert (com_out !== {2{com_pol}}) else $error("FAIL both_commons com_out=%b com_pol=%b", com_out, com_pol);
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_and_basic();
    logic [1:0] ec;
    logic [7:0] es;
    rst_n = 1'b0; ena = 1'b1; value_valid = 1'b0; value_bcd = 8'h00; value_dp = 2'b00;
    lz_blank = 1'b0; com_pol = 1'b0; seg_pol = 1'b1;
    #2;
    cyc(); cyc();
    checks++;
    if (com_oe !== 2'b00) begin failures++; $display("FAIL reset_oe com_oe=%b exp=00", com_oe); end
    checks++;
    if (com_out !== 2'b11 || seg_out !== 8'h00) begin
      failures++; $display("FAIL reset_out com_out=%b exp=11 seg_out=%h exp=00", com_out, seg_out);
    end
    rst_n = 1'b1; value_valid = 1'b1; value_bcd = 8'h42;
    checks++;
    if (value_ready !== 1'b1) begin failures++; $display("FAIL basic_ready ready=%b exp=1", value_ready); end
    for (int k = 0; k < 24; k++) begin
      cyc();
      if (k == 0) begin
        value_valid = 1'b0;
        checks++;
        if (com_oe !== 2'b11) begin failures++; $display("FAIL basic_oe com_oe=%b exp=11", com_oe); end
      end
      ec = (k < 4 || (k >= 12 && k < 16)) ? 2'b00 : k < 12 ? 2'b10 : 2'b01;
      es = ec == 2'b10 ? 8'h66 : ec == 2'b01 ? 8'h5B : 8'h00;
      checks++;
      if (com_out !== ~ec || seg_out !== es) begin
        failures++; $display("FAIL basic k=%0d com_out=%b exp=%b seg_out=%h exp=%h", k, com_out, ~ec, seg_out, es);
      end
    end
  endtask
  task automatic test_polarity();
    logic [1:0] ec;
    logic [7:0] es;
    com_pol = 1'b1; seg_pol = 1'b0;
    for (int k = 0; k < 24; k++) begin
      cyc();
      ec = (k < 4 || (k >= 12 && k < 16)) ? 2'b00 : k < 12 ? 2'b10 : 2'b01;
      es = ec == 2'b10 ? 8'h99 : ec == 2'b01 ? 8'hA4 : 8'hFF;
      checks++;
      if (com_out !== ec || seg_out !== es) begin
        failures++; $display("FAIL polarity k=%0d com_out=%b exp=%b seg_out=%h exp=%h", k, com_out, ec, seg_out, es);
      end
    end
  endtask
  task automatic test_lz_blank();
    logic [1:0] ec;
    logic [7:0] es, t;
    com_pol = 1'b1; seg_pol = 1'b1;
    for (int f = 0; f < 2; f++) begin
      lz_blank = (f == 0);
      t = f == 0 ? 8'h80 : 8'hBF;
      if (f == 0) begin value_valid = 1'b1; value_bcd = 8'h07; value_dp = 2'b10; end
      for (int k = 0; k < 24; k++) begin
        cyc();
        value_valid = 1'b0;
        ec = (k < 4 || (k >= 12 && k < 16)) ? 2'b00 : k < 12 ? 2'b10 : 2'b01;
        es = ec == 2'b10 ? t : ec == 2'b01 ? 8'h07 : 8'h00;
        checks++;
        if (com_out !== ec || seg_out !== es) begin
          failures++; $display("FAIL lz f=%0d k=%0d com_out=%b exp=%b seg_out=%h exp=%h", f, k, com_out, ec, seg_out, es);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [1:0] ec;
    logic [7:0] es, t, o;
    for (int f = 0; f < 3; f++) begin
      t = f == 0 ? 8'hBF : f == 1 ? 8'h6F : 8'h4F;
      o = f == 0 ? 8'h07 : f == 1 ? 8'h6F : 8'h6D;
      if (f == 2) begin value_valid = 1'b1; value_bcd = 8'h12; value_dp = 2'b01; end
      for (int k = 0; k < 24; k++) begin
        cyc();
        if (f == 1 && k == 0) value_valid = 1'b0;
        if (f == 2 && k == 0) begin value_bcd = 8'h35; value_dp = 2'b00; end
        if (f == 2 && k == 1) value_valid = 1'b0;
        if (f == 0 && k == 7) begin value_valid = 1'b1; value_bcd = 8'h99; value_dp = 2'b00; end
        if (f == 0 && k >= 7) begin
          checks++;
          if (value_ready !== (k == 23)) begin
            failures++; $display("FAIL hold_ready k=%0d ready=%b exp=%b", k, value_ready, k == 23);
          end
        end
        ec = (k < 4 || (k >= 12 && k < 16)) ? 2'b00 : k < 12 ? 2'b10 : 2'b01;
        es = ec == 2'b10 ? t : ec == 2'b01 ? o : 8'h00;
        checks++;
        if (com_out !== ec || seg_out !== es) begin
          failures++; $display("FAIL b2b f=%0d k=%0d com_out=%b exp=%b seg_out=%h exp=%h", f, k, com_out, ec, seg_out, es);
        end
      end
    end
  endtask
  task automatic test_ena_freeze();
    logic [1:0] ec;
    logic [7:0] es;
    for (int k = 0; k < 24; k++) begin
      if (k == 19) begin
        ena = 1'b0;
        for (int j = 0; j < 10; j++) begin
          cyc();
          checks++;
          if (com_out !== 2'b00 || seg_out !== 8'h00 || value_ready !== 1'b0 || com_oe !== 2'b11) begin
            failures++;
            $display("FAIL ena_dark j=%0d com_out=%b seg_out=%h ready=%b oe=%b exp=00/00/0/11", j, com_out, seg_out, value_ready, com_oe);
          end
        end
        ena = 1'b1;
      end
      cyc();
      ec = (k < 4 || (k >= 12 && k < 16)) ? 2'b00 : k < 12 ? 2'b10 : 2'b01;
      es = ec == 2'b10 ? 8'h4F : ec == 2'b01 ? 8'h6D : 8'h00;
      checks++;
      if (com_out !== ec || seg_out !== es) begin
        failures++; $display("FAIL ena k=%0d com_out=%b exp=%b seg_out=%h exp=%h", k, com_out, ec, seg_out, es);
      end
    end
    cyc();
    checks++;
    if (com_out !== 2'b00 || seg_out !== 8'h00) begin
      failures++; $display("FAIL ena_gap com_out=%b seg_out=%h exp=00/00", com_out, seg_out);
    end
    for (int k = 0; k < 23; k++) cyc();
  endtask
  task automatic test_reset_mid();
    logic [1:0] ec;
    logic [7:0] es;
    for (int k = 0; k < 8; k++) cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if (com_oe !== 2'b00 || com_out !== 2'b00 || seg_out !== 8'h00) begin
      failures++; $display("FAIL rst_async oe=%b com_out=%b seg_out=%h exp=00/00/00", com_oe, com_out, seg_out);
    end
    cyc(); cyc();
    checks++;
    if (com_oe !== 2'b00 || com_out !== 2'b00 || seg_out !== 8'h00) begin
      failures++; $display("FAIL rst_hold oe=%b com_out=%b seg_out=%h exp=00/00/00", com_oe, com_out, seg_out);
    end
    rst_n = 1'b1;
    checks++;
    if (value_ready !== 1'b1) begin failures++; $display("FAIL rst_ready ready=%b exp=1", value_ready); end
    for (int k = 0; k < 24; k++) begin
      cyc();
      ec = (k < 4 || (k >= 12 && k < 16)) ? 2'b00 : k < 12 ? 2'b10 : 2'b01;
      es = ec == 2'b00 ? 8'h00 : 8'h3F;
      checks++;
      if (com_out !== ec || seg_out !== es || com_oe !== 2'b11) begin
        failures++; $display("FAIL rst_frame k=%0d com_out=%b exp=%b seg_out=%h exp=%h oe=%b", k, com_out, ec, seg_out, es, com_oe);
      end
    end
  endtask
  initial begin
    test_reset_and_basic();
    test_polarity();
    test_lz_blank();
    test_back_to_back();
    test_ena_freeze();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
